hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS core (F/D/E/M/W).
//  Produces per-stage stall/flush and forwarding selects from decoded register indices.
//  Owns the multi-cycle MULT/DIV (HI/LO) busy state machine.
//  Interlocks the core against instruction- and data-bus wait states.
//  Sits beside the datapath in mycpu; purely a control block, no data path through it.
// PARAMETERS
//  MULT_LAT  4   cycles from accepted MULT/MULTU start until HI/LO valid (>=1)
//  DIV_LAT   33  cycles from accepted DIV/DIVU start until HI/LO valid (>=1)
// PORTS
//  clk        in   1  core clock
//  resetn     in   1  synchronous active-low reset
//  rsD,rtD    in   5  source regs of instr in D
//  useRsD,useRtD in 1  D instr reads rs/rt
//  branchD    in   1  D instr is a branch/JR that compares/reads regs in D
//  rsE,rtE    in   5  source regs of instr in E
//  rdE        in   5  dest reg of E; regwriteE, memtoregE: in, 1 bit each
//  rdM        in   5  dest reg of M; regwriteM, memtoregM: in, 1 bit each
//  rdW        in   5  dest reg of W; regwriteW: in, 1 bit
//  mduStartE  in   1  E holds MULT/MULTU/DIV/DIVU
//  mduDivE    in   1  1=divide, 0=multiply (valid with mduStartE)
//  hiloReadE  in   1  E holds MFHI/MFLO
//  iBusy      in   1  instruction fetch not complete this cycle
//  dBusy      in   1  data access in M not complete this cycle
//  stallF,stallD,stallE,stallM  out 1  hold stage register
//  flushD,flushE,flushM,flushW  out 1  load bubble into stage register
//  fwdAE,fwdBE out 2  E operand select: 00 regfile, 01 W result, 10 M result
//  fwdAD,fwdBD out 1  D branch operand: 1 = take M result
//  mduBusy    out  1  HI/LO operation in flight
// BEHAVIOUR
//  Reset (resetn=0 at posedge): state IDLE, cnt=0.
//  Reset (comb. while resetn=0): all stall*=0, all flush*=1, fwd*=0, mduBusy=0.
//  Reset mid-operation: MDU op abandoned, next cycle IDLE.
//  Forwarding (comb.): fwdAE=10 if regwriteM & rdM!=0 & rdM==rsE.
//    Else fwdAE=01 if regwriteW & rdW!=0 & rdW==rsE; else 00. fwdBE same with rtE.
//  fwdAD=regwriteM & !memtoregM & rdM!=0 & rdM==rsD; fwdBD same with rtD.
//  Hazard terms (all require rd!=0):
//    LU  = memtoregE & rdE matches (useRsD&rsD | useRtD&rtD).
//    BR  = branchD & (regwriteE & rdE matches used src, or memtoregM & rdM matches used src).
//    MDH = (hiloReadE | mduStartE) & state==BUSY.
//  Priority (highest first), outputs not listed are 0:
//    1 dBusy:  stallF,D,E,M=1, flushW=1.
//    2 MDH:    stallF,D,E=1, flushM=1.
//    3 LU|BR:  stallF,D=1, flushE=1.
//    4 iBusy:  stallF=1, flushD=1.
//  MDU FSM, states IDLE, BUSY:
//    IDLE->BUSY when mduStartE & !stallE; cnt<=(mduDivE?DIV_LAT:MULT_LAT)-1.
//    BUSY: cnt decrements every cycle, including cycles stalled by dBusy.
//    BUSY->IDLE when cnt==0.
//  mduBusy=(state==BUSY), registered. MFHI/MFLO in E proceeds the first cycle mduBusy=0.
//  A second start while BUSY stalls (MDH) and is accepted the cycle after IDLE returns.
//  cnt width $clog2(DIV_LAT>MULT_LAT?DIV_LAT:MULT_LAT)+1.
//  LAT=1: one cycle of BUSY.
// TESTING
//  T1 fwd: rdM=5,regwriteM=1,rdW=5,regwriteW=1,rsE=5 -> fwdAE=10.
//     Then rdM=0 -> fwdAE=01; rsE=0 -> 00.
//  T2 load-use: memtoregE=1,rdE=8,rsD=8,useRsD=1 -> stallF=stallD=flushE=1 one cycle.
//     Same stimulus with rdE=0 -> no stall.
//  T3 DIV then MFLO: mduStartE,mduDivE=1 accepted at cycle 0 -> mduBusy=1 cycles 1..33.
//     hiloReadE stalls F/D/E with flushM=1 through cycle 33; released cycle 34.
//  T4 priority: dBusy=1 & LU & iBusy same cycle -> only stallF..M=1, flushW=1.
//     Drop dBusy -> LU response.
//  T5 reset mid-MULT: resetn=0 at cnt=2 -> next cycle mduBusy=0, all flush*=1 while low.
//  T6 iBusy alone 3 cycles -> stallF=1, flushD=1 each cycle, no other stalls.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stall/flush, forwarding selects,
// and the multi-cycle HI/LO busy tracker.
module hazard_ctrl #(
   parameter int MULT_LAT = 4,
   parameter int DIV_LAT  = 33
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [4:0] rsD,
   input  logic [4:0] rtD,
   input  logic       useRsD,
   input  logic       useRtD,
   input  logic       branchD,
   input  logic [4:0] rsE,
   input  logic [4:0] rtE,
   input  logic [4:0] rdE,
   input  logic       regwriteE,
   input  logic       memtoregE,
   input  logic [4:0] rdM,
   input  logic       regwriteM,
   input  logic       memtoregM,
   input  logic [4:0] rdW,
   input  logic       regwriteW,
   input  logic       mduStartE,
   input  logic       mduDivE,
   input  logic       hiloReadE,
   input  logic       iBusy,
   input  logic       dBusy,
   output logic       stallF,
   output logic       stallD,
   output logic       stallE,
   output logic       stallM,
   output logic       flushD,
   output logic       flushE,
   output logic       flushM,
   output logic       flushW,
   output logic [1:0] fwdAE,
   output logic [1:0] fwdBE,
   output logic       fwdAD,
   output logic       fwdBD,
   output logic       mduBusy
);

   localparam int MAXLAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
   localparam int CW     = $clog2(MAXLAT) + 1;
   localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT - 1);
   localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT - 1);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic busy;
   logic lu_haz, br_haz, mdh_haz;
   logic mW_hit, eW_hit;
   logic sel_d, sel_mdh, sel_lb, sel_i;
   logic stall_e;

   assign busy = (state_q == BUSY);

   // Does the D instruction read register r (r must be nonzero)
   function automatic logic d_reads(input logic [4:0] r);
      return (r != 5'd0) &&
             ((useRsD && rsD == r) || (useRtD && rtD == r));
   endfunction

   assign eW_hit  = regwriteE && d_reads(rdE);
   assign mW_hit  = memtoregM && d_reads(rdM);
   assign lu_haz  = memtoregE && d_reads(rdE);
   assign br_haz  = branchD && (eW_hit || mW_hit);
   assign mdh_haz = (hiloReadE || mduStartE) && busy;

   assign sel_d   = dBusy;
   assign sel_mdh = !dBusy && mdh_haz;
   assign sel_lb  = !dBusy && !mdh_haz && (lu_haz || br_haz);
   assign sel_i   = !dBusy && !mdh_haz && !(lu_haz || br_haz) && iBusy;

   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stall_e = 1'b0;
      stallM = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      flushM = 1'b0;
      flushW = 1'b0;
      if (!resetn) begin
         flushD = 1'b1;
         flushE = 1'b1;
         flushM = 1'b1;
         flushW = 1'b1;
      end else begin
         unique case (1'b1)
            sel_d: begin
               stallF  = 1'b1;
               stallD  = 1'b1;
               stall_e = 1'b1;
               stallM  = 1'b1;
               flushW  = 1'b1;
            end
            sel_mdh: begin
               stallF  = 1'b1;
               stallD  = 1'b1;
               stall_e = 1'b1;
               flushM  = 1'b1;
            end
            sel_lb: begin
               stallF = 1'b1;
               stallD = 1'b1;
               flushE = 1'b1;
            end
            sel_i: begin
               stallF = 1'b1;
               flushD = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign stallE = stall_e;

   always_comb begin
      fwdAE = 2'b00;
      fwdBE = 2'b00;
      fwdAD = 1'b0;
      fwdBD = 1'b0;
      if (resetn) begin
         if (regwriteM && rdM != 5'd0 && rdM == rsE)
            fwdAE = 2'b10;
         else if (regwriteW && rdW != 5'd0 && rdW == rsE)
            fwdAE = 2'b01;
         if (regwriteM && rdM != 5'd0 && rdM == rtE)
            fwdBE = 2'b10;
         else if (regwriteW && rdW != 5'd0 && rdW == rtE)
            fwdBE = 2'b01;
         fwdAD = regwriteM && !memtoregM &&
                 rdM != 5'd0 && rdM == rsD;
         fwdBD = regwriteM && !memtoregM &&
                 rdM != 5'd0 && rdM == rtD;
      end
   end

   // Counter keeps running under dBusy so latency is wall-clock cycles
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (mduStartE && !stall_e) begin
               state_d = BUSY;
               cnt_d   = mduDivE ? DIV_CNT : MULT_CNT;
            end
         end
         BUSY: begin
            if (cnt_q == '0)
               state_d = IDLE;
            else
               cnt_d = cnt_q - CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mduBusy = resetn && busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl against a
// remaining-cycles reference model.
module tb_hazard_ctrl;

   localparam int MULT_LAT = 4;
   localparam int DIV_LAT  = 33;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetn;
   logic [4:0] rsD, rtD, rsE, rtE, rdE, rdM, rdW;
   logic       useRsD, useRtD, branchD;
   logic       regwriteE, memtoregE, regwriteM, memtoregM, regwriteW;
   logic       mduStartE, mduDivE, hiloReadE, iBusy, dBusy;
   logic       stallF, stallD, stallE, stallM;
   logic       flushD, flushE, flushM, flushW;
   logic [1:0] fwdAE, fwdBE;
   logic       fwdAD, fwdBD, mduBusy;

   int n_chk = 0;
   int n_pass = 0;
   int busy_left = 0;

   hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .resetn(resetn),
      .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
      .branchD(branchD), .rsE(rsE), .rtE(rtE),
      .rdE(rdE), .regwriteE(regwriteE), .memtoregE(memtoregE),
      .rdM(rdM), .regwriteM(regwriteM), .memtoregM(memtoregM),
      .rdW(rdW), .regwriteW(regwriteW),
      .mduStartE(mduStartE), .mduDivE(mduDivE),
      .hiloReadE(hiloReadE), .iBusy(iBusy), .dBusy(dBusy),
      .stallF(stallF), .stallD(stallD), .stallE(stallE),
      .stallM(stallM), .flushD(flushD), .flushE(flushE),
      .flushM(flushM), .flushW(flushW),
      .fwdAE(fwdAE), .fwdBE(fwdBE), .fwdAD(fwdAD), .fwdBD(fwdBD),
      .mduBusy(mduBusy)
   );

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [7:0] sf_vec();
      return {stallF, stallD, stallE, stallM,
              flushD, flushE, flushM, flushW};
   endfunction

   function automatic bit reads(input logic [4:0] r);
      return r != 0 && ((useRsD && rsD == r) || (useRtD && rtD == r));
   endfunction

   function automatic logic [1:0] fwd_e(input logic [4:0] src);
      if (regwriteM && rdM != 0 && rdM == src) return 2'b10;
      if (regwriteW && rdW != 0 && rdW == src) return 2'b01;
      return 2'b00;
   endfunction

   // Check every output against the model, then advance one clock
   task automatic step();
      logic [7:0] sf;
      logic [1:0] eA, eB;
      logic eAD, eBD, eBusy;
      bit lu, br, mdh;
      #1;
      if (!resetn) begin
         sf = 8'b0000_1111;
         eA = 0; eB = 0; eAD = 0; eBD = 0; eBusy = 0;
      end else begin
         eA = fwd_e(rsE);
         eB = fwd_e(rtE);
         eAD = regwriteM && !memtoregM && rdM != 0 && rdM == rsD;
         eBD = regwriteM && !memtoregM && rdM != 0 && rdM == rtD;
         eBusy = busy_left > 0;
         lu = memtoregE && reads(rdE);
         br = branchD && ((regwriteE && reads(rdE)) ||
                          (memtoregM && reads(rdM)));
         mdh = (hiloReadE || mduStartE) && busy_left > 0;
         if (dBusy) sf = 8'b1111_0001;
         else if (mdh) sf = 8'b1110_0010;
         else if (lu || br) sf = 8'b1100_0100;
         else if (iBusy) sf = 8'b1000_1000;
         else sf = 8'b0;
      end
      check("stall_flush", sf_vec(), sf);
      check("fwdAE", fwdAE, eA);
      check("fwdBE", fwdBE, eB);
      check("fwdAD", fwdAD, eAD);
      check("fwdBD", fwdBD, eBD);
      check("mduBusy", mduBusy, eBusy);
      if (!resetn) busy_left = 0;
      else if (busy_left > 0) busy_left--;
      else if (mduStartE && !sf[5])
         busy_left = mduDivE ? DIV_LAT : MULT_LAT;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      resetn = 1;
      rsD = 0; rtD = 0; rsE = 0; rtE = 0;
      rdE = 0; rdM = 0; rdW = 0;
      useRsD = 0; useRtD = 0; branchD = 0;
      regwriteE = 0; memtoregE = 0;
      regwriteM = 0; memtoregM = 0; regwriteW = 0;
      mduStartE = 0; mduDivE = 0; hiloReadE = 0;
      iBusy = 0; dBusy = 0;
   endtask

   initial begin
      idle_inputs();
      resetn = 0;
      @(posedge clk);
      #1;
      #1 check("rst_flush", sf_vec(), 8'b0000_1111);
      check("rst_busy", mduBusy, 0);
      step();
      step();

      // T1 forwarding priority
      idle_inputs();
      rdM = 5; regwriteM = 1; rdW = 5; regwriteW = 1; rsE = 5;
      #1 check("T1_fwdM", fwdAE, 2'b10);
      step();
      rdM = 0;
      #1 check("T1_fwdW", fwdAE, 2'b01);
      step();
      rsE = 0;
      #1 check("T1_zero", fwdAE, 2'b00);
      step();

      // T2 load-use
      idle_inputs();
      memtoregE = 1; rdE = 8; rsD = 8; useRsD = 1;
      #1 check("T2_lu", sf_vec(), 8'b1100_0100);
      step();
      rdE = 0;
      #1 check("T2_r0", sf_vec(), 8'b0);
      step();

      // T3 DIV then MFLO
      idle_inputs();
      mduStartE = 1; mduDivE = 1;
      step();
      mduStartE = 0; mduDivE = 0; hiloReadE = 1;
      for (int c = 1; c <= 33; c++) begin
         #1 check("T3_busy", mduBusy, 1);
         check("T3_stall", sf_vec(), 8'b1110_0010);
         step();
      end
      #1 check("T3_rel_busy", mduBusy, 0);
      check("T3_rel", sf_vec(), 8'b0);
      step();

      // T4 priority
      idle_inputs();
      dBusy = 1; iBusy = 1;
      memtoregE = 1; rdE = 8; rsD = 8; useRsD = 1;
      #1 check("T4_dbusy", sf_vec(), 8'b1111_0001);
      step();
      dBusy = 0;
      #1 check("T4_lu", sf_vec(), 8'b1100_0100);
      step();

      // T5 reset mid-MULT
      idle_inputs();
      mduStartE = 1;
      step();
      mduStartE = 0;
      step();
      resetn = 0;
      #1 check("T5_flush", sf_vec(), 8'b0000_1111);
      check("T5_busy_low", mduBusy, 0);
      step();
      resetn = 1;
      #1 check("T5_idle", mduBusy, 0);
      step();

      // T6 iBusy alone
      idle_inputs();
      iBusy = 1;
      for (int c = 0; c < 3; c++) begin
         #1 check("T6_ibusy", sf_vec(), 8'b1000_1000);
         step();
      end

      // Randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         resetn    = ($urandom_range(0, 199) != 0);
         rsD = 5'($urandom_range(0, 3));
         rtD = 5'($urandom_range(0, 3));
         rsE = 5'($urandom_range(0, 3));
         rtE = 5'($urandom_range(0, 3));
         rdE = 5'($urandom_range(0, 3));
         rdM = 5'($urandom_range(0, 3));
         rdW = 5'($urandom_range(0, 3));
         useRsD    = 1'($urandom);
         useRtD    = 1'($urandom);
         branchD   = ($urandom_range(0, 3) == 0);
         regwriteE = 1'($urandom);
         memtoregE = ($urandom_range(0, 3) == 0);
         regwriteM = 1'($urandom);
         memtoregM = ($urandom_range(0, 3) == 0);
         regwriteW = 1'($urandom);
         mduStartE = ($urandom_range(0, 9) == 0);
         mduDivE   = ($urandom_range(0, 3) == 0);
         hiloReadE = ($urandom_range(0, 3) == 0);
         iBusy     = ($urandom_range(0, 4) == 0);
         dBusy     = ($urandom_range(0, 7) == 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
